// File: rtl/pfpu_wbarb.sv
// Write-back arbiter: merges add/sub and multiplier results onto one register-file
// write port, holding collisions in an in-order skid FIFO with zero flush at selection.
module pfpu_wbarb #(
    parameter int DEPTH       = 4,
    parameter int STALL_LEVEL = 2
) (
    input  logic        sys_clk,
    input  logic        alu_rst,
    input  logic        a_valid,
    input  logic [31:0] a_r,
    input  logic [6:0]  a_dst,
    input  logic        m_valid,
    input  logic [31:0] m_r,
    input  logic [6:0]  m_dst,
    output logic        regf_we,
    output logic [6:0]  regf_waddr,
    output logic [31:0] regf_wdat,
    output logic        stall,
    output logic        busy,
    output logic        overflow
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [6:0]  dst;
        logic [31:0] r;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] wr_ptr1;
    logic [AW:0]   occ;

    entry_t        a_ent, m_ent, head, sel, push0, push1;
    logic          sel_vld, pop, want0, want1, acc0, acc1, drop;
    logic [AW+1:0] free;
    logic [AW:0]   n_push;

    // Denormals and zeros of either sign are written as +0.0.
    function automatic logic [31:0] flush_zero(input logic [31:0] r);
        return (r[30:23] == 8'd0) ? 32'd0 : r;
    endfunction

    // Selection order is FIFO head, then a, then m; unselected valid inputs queue
    // in a-then-m order so nothing overtakes an earlier result.
    always_comb begin
        a_ent   = '{dst: a_dst, r: a_r};
        m_ent   = '{dst: m_dst, r: m_r};
        head    = mem[rd_ptr];
        pop     = (occ != '0);
        sel     = head;
        sel_vld = 1'b0;
        want0   = 1'b0;
        want1   = 1'b0;
        push0   = a_ent;
        push1   = m_ent;
        if (pop) begin
            sel_vld = 1'b1;
            if (a_valid) begin
                want0 = 1'b1;
                want1 = m_valid;
            end else if (m_valid) begin
                want0 = 1'b1;
                push0 = m_ent;
            end
        end else if (a_valid) begin
            sel     = a_ent;
            sel_vld = 1'b1;
            if (m_valid) begin
                want0 = 1'b1;
                push0 = m_ent;
            end
        end else if (m_valid) begin
            sel     = m_ent;
            sel_vld = 1'b1;
        end
        // Space freed by this cycle's pop is usable by this cycle's pushes.
        free    = (AW+2)'(DEPTH) - {1'b0, occ} + (AW+2)'(pop);
        acc0    = want0 && (free != '0);
        acc1    = want1 && acc0 && (free >= (AW+2)'(2));
        drop    = (want0 && !acc0) || (want1 && !acc1);
        n_push  = (AW+1)'(acc0) + (AW+1)'(acc1);
        wr_ptr1 = wr_ptr + AW'(1);
    end

    always_ff @(posedge sys_clk or posedge alu_rst) begin
        if (alu_rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            occ        <= '0;
            regf_we    <= 1'b0;
            regf_waddr <= '0;
            regf_wdat  <= '0;
            overflow   <= 1'b0;
        end else begin
            regf_we <= sel_vld;
            if (sel_vld) begin
                regf_waddr <= sel.dst;
                regf_wdat  <= flush_zero(sel.r);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            wr_ptr <= wr_ptr + n_push[AW-1:0];
            occ    <= occ + n_push - (AW+1)'(pop);
            if (drop)
                overflow <= 1'b1;
        end
    end

    // Storage needs no reset: entries are only read while occupancy covers them.
    always_ff @(posedge sys_clk) begin
        if (acc0)
            mem[wr_ptr] <= push0;
        if (acc1)
            mem[wr_ptr1] <= push1;
    end

    assign stall = (occ >= (AW+1)'(STALL_LEVEL));
    assign busy  = (occ != '0) || regf_we;

endmodule

// File: tb/tb_pfpu_wbarb.sv
// Self-checking bench for pfpu_wbarb: directed table, corner sequences and random
// traffic compared against a queue-based model of the write-back order.
module tb_pfpu_wbarb;
    localparam int DEPTH       = 4;
    localparam int STALL_LEVEL = 2;

    logic        sys_clk = 1'b0;
    logic        alu_rst;
    logic        a_valid, m_valid;
    logic [31:0] a_r, m_r;
    logic [6:0]  a_dst, m_dst;
    logic        regf_we;
    logic [6:0]  regf_waddr;
    logic [31:0] regf_wdat;
    logic        stall, busy, overflow;

    pfpu_wbarb #(.DEPTH(DEPTH), .STALL_LEVEL(STALL_LEVEL)) dut (
        .sys_clk    (sys_clk),
        .alu_rst    (alu_rst),
        .a_valid    (a_valid),
        .a_r        (a_r),
        .a_dst      (a_dst),
        .m_valid    (m_valid),
        .m_r        (m_r),
        .m_dst      (m_dst),
        .regf_we    (regf_we),
        .regf_waddr (regf_waddr),
        .regf_wdat  (regf_wdat),
        .stall      (stall),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 sys_clk = ~sys_clk;

    int checks   = 0;
    int failures = 0;

    // Model: pending results in write order, plus the registered output state.
    logic [38:0] q[$];
    logic        m_we;
    logic [6:0]  m_waddr;
    logic [31:0] m_wdat;
    logic        m_ovf;
    logic [38:0] got[$];

    typedef struct {
        logic        av;
        logic [31:0] ar;
        logic [6:0]  ad;
        logic        mv;
        logic [31:0] mr;
        logic [6:0]  md;
        logic        we;
        logic [6:0]  wa;
        logic [31:0] wd;
        logic        bsy;
        logic        stl;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [38:0] act, input logic [38:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_flush(input logic [31:0] r);
        if (r[30:23] == 8'd0) return 32'd0;
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        m_we    = 1'b0;
        m_waddr = '0;
        m_wdat  = '0;
        m_ovf   = 1'b0;
    endtask

    // One clock: check start-of-cycle hints, drive inputs, advance model, check outputs.
    task automatic step(input logic av, input logic [31:0] ar, input logic [6:0] ad,
                        input logic mv, input logic [31:0] mr, input logic [6:0] md);
        logic [38:0] cand[$];
        logic [38:0] e;
        check("stall_pre", 39'(stall), 39'(q.size() >= STALL_LEVEL));
        check("busy_pre", 39'(busy), 39'((q.size() != 0) || m_we));
        a_valid = av; a_r = ar; a_dst = ad;
        m_valid = mv; m_r = mr; m_dst = md;
        cand = q;
        if (av) cand.push_back({ad, ar});
        if (mv) cand.push_back({md, mr});
        if (cand.size() > 0) begin
            e       = cand.pop_front();
            m_we    = 1'b1;
            m_waddr = e[38:32];
            m_wdat  = model_flush(e[31:0]);
        end else begin
            m_we = 1'b0;
        end
        while (cand.size() > DEPTH) begin
            void'(cand.pop_back());
            m_ovf = 1'b1;
        end
        q = cand;
        @(posedge sys_clk);
        #1;
        check("regf_we", 39'(regf_we), 39'(m_we));
        check("regf_waddr", 39'(regf_waddr), 39'(m_waddr));
        check("regf_wdat", 39'(regf_wdat), 39'(m_wdat));
        check("overflow", 39'(overflow), 39'(m_ovf));
        if (regf_we) got.push_back({regf_waddr, regf_wdat});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 32'd0, 7'd0, 1'b0, 32'd0, 7'd0);
    endtask

    task automatic do_reset();
        alu_rst = 1'b1;
        #1;
        check("rst_we", 39'(regf_we), 39'(0));
        check("rst_busy", 39'(busy), 39'(0));
        check("rst_stall", 39'(stall), 39'(0));
        check("rst_ovf", 39'(overflow), 39'(0));
        @(posedge sys_clk);
        #1;
        alu_rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [38:0] exp_list[$];
        logic [31:0] ra, rm;

        tbl[0] = '{1'b1, 32'h3F800000, 7'd5,  1'b0, 32'h0,        7'd0,  1'b1, 7'd5,  32'h3F800000, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 32'h0,        7'd0,  1'b0, 32'h0,        7'd0,  1'b0, 7'd5,  32'h3F800000, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 32'h40000000, 7'd1,  1'b1, 32'h40400000, 7'd2,  1'b1, 7'd1,  32'h40000000, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 32'h0,        7'd0,  1'b0, 32'h0,        7'd0,  1'b1, 7'd2,  32'h40400000, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 32'h0,        7'd0,  1'b0, 32'h0,        7'd0,  1'b0, 7'd2,  32'h40400000, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 32'h0,        7'd0,  1'b1, 32'h80400000, 7'd9,  1'b1, 7'd9,  32'h00000000, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 32'h0,        7'd0,  1'b1, 32'h80800000, 7'd10, 1'b1, 7'd10, 32'h80800000, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 32'h0,        7'd0,  1'b0, 32'h0,        7'd0,  1'b0, 7'd10, 32'h80800000, 1'b0, 1'b0};

        a_valid = 1'b0; a_r = '0; a_dst = '0;
        m_valid = 1'b0; m_r = '0; m_dst = '0;
        alu_rst = 1'b1;
        model_reset();
        @(posedge sys_clk);
        @(posedge sys_clk);
        #1;
        check("init_we", 39'(regf_we), 39'(0));
        check("init_waddr", 39'(regf_waddr), 39'(0));
        check("init_wdat", 39'(regf_wdat), 39'(0));
        check("init_busy", 39'(busy), 39'(0));
        check("init_stall", 39'(stall), 39'(0));
        check("init_ovf", 39'(overflow), 39'(0));
        alu_rst = 1'b0;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].av, tbl[i].ar, tbl[i].ad, tbl[i].mv, tbl[i].mr, tbl[i].md);
            check($sformatf("tbl%0d_we", i), 39'(regf_we), 39'(tbl[i].we));
            check($sformatf("tbl%0d_waddr", i), 39'(regf_waddr), 39'(tbl[i].wa));
            check($sformatf("tbl%0d_wdat", i), 39'(regf_wdat), 39'(tbl[i].wd));
            check($sformatf("tbl%0d_busy", i), 39'(busy), 39'(tbl[i].bsy));
            check($sformatf("tbl%0d_stall", i), 39'(stall), 39'(tbl[i].stl));
        end

        // Fill to capacity and overflow on the fifth dual arrival
        got.delete();
        exp_list.delete();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 32'h41000000 + 32'(i), 7'(10 + i), 1'b1, 32'h42000000 + 32'(i), 7'(20 + i));
            check($sformatf("fill%0d_stall", i), 39'(stall), 39'(i >= 1));
            check($sformatf("fill%0d_ovf", i), 39'(overflow), 39'(i == 4));
            exp_list.push_back({7'(10 + i), 32'h41000000 + 32'(i)});
            if (i < 4) exp_list.push_back({7'(20 + i), 32'h42000000 + 32'(i)});
        end
        idle(6);
        check("fill_count", 39'(got.size()), 39'(exp_list.size()));
        for (int i = 0; i < exp_list.size() && i < got.size(); i++)
            check($sformatf("fill_order%0d", i), got[i], exp_list[i]);
        check("fill_ovf_sticky", 39'(overflow), 39'(1));
        do_reset();

        // Wrap-around: dual arrival followed by idle, twelve times
        got.delete();
        exp_list.delete();
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 32'h3F000000 + 32'(i), 7'(i), 1'b1, 32'h43000000 + 32'(i), 7'(64 + i));
            step(1'b0, 32'd0, 7'd0, 1'b0, 32'd0, 7'd0);
            exp_list.push_back({7'(i), 32'h3F000000 + 32'(i)});
            exp_list.push_back({7'(64 + i), 32'h43000000 + 32'(i)});
        end
        idle(2);
        check("wrap_count", 39'(got.size()), 39'(24));
        for (int i = 0; i < exp_list.size() && i < got.size(); i++)
            check($sformatf("wrap_order%0d", i), got[i], exp_list[i]);

        // Async reset with three entries queued
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'h44000000 + 32'(i), 7'(30 + i), 1'b1, 32'h45000000 + 32'(i), 7'(40 + i));
        check("pre_rst_stall", 39'(stall), 39'(1));
        a_valid = 1'b0;
        m_valid = 1'b0;
        #2;
        do_reset();
        got.delete();
        idle(5);
        check("post_rst_writes", 39'(got.size()), 39'(0));

        // Random traffic against the model, including drops and exponent-zero words
        for (int i = 0; i < 400; i++) begin
            ra = $urandom;
            rm = $urandom;
            if ($urandom_range(0, 3) == 0) ra[30:23] = 8'd0;
            if ($urandom_range(0, 3) == 0) rm[30:23] = 8'd0;
            step(1'($urandom_range(0, 99) < 55), ra, 7'($urandom),
                 1'($urandom_range(0, 99) < 55), rm, 7'($urandom));
            if (i == 200) do_reset();
        end
        idle(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pfpu_wbarb.md
# pfpu_wbarb

Write-back arbiter for the PFPU datapath. It sits directly downstream of the floating-point add/subtract unit and the multiplier, and merges their result streams onto the single register-file write port. Results that cannot be written in the cycle they arrive are held in a small in-order skid FIFO. Denormal/zero results are flushed to +0.0, and a stall hint is raised for the issue logic when the FIFO approaches capacity.

## Interface
Parameters:
- DEPTH, 4, skid FIFO entries; power of two, ≥ 4.
- STALL_LEVEL, 2, `stall` asserts when occupancy ≥ STALL_LEVEL.

Ports:
- sys_clk  in  1  system clock; all state on rising edge.
- alu_rst  in  1  reset; one clock, asynchronous, active-high.
- a_valid  in  1  add/sub result valid, single-cycle pulse per result.
- a_r  in  32  add/sub result, IEEE-754 single.
- a_dst  in  7  destination register for `a_r`.
- m_valid  in  1  multiplier result valid.
- m_r  in  32  multiplier result.
- m_dst  in  7  destination register for `m_r`.
- regf_we  out  1  register-file write enable; registered.
- regf_waddr  out  7  write address; registered.
- regf_wdat  out  32  write data; registered.
- stall  out  1  issue-throttle hint; combinational from the occupancy register.
- busy  out  1  FIFO non-empty or `regf_we` high; combinational from registers.
- overflow  out  1  sticky: a result was dropped; registered.

## Operation
- Reset, asynchronous: `regf_we`=0, `regf_waddr`=0, `regf_wdat`=0, `overflow`=0, occupancy=0, read/write pointers=0.
  - Therefore `stall`=0 and `busy`=0 during reset.
  - Reset asserted mid-operation discards all FIFO contents and any pending write.
- Each cycle, exactly one candidate is selected for write, in priority order:
  1. FIFO head, if occupancy > 0.
  2. Else `a` input, if `a_valid`.
  3. Else `m` input, if `m_valid`.
  4. Else none: `regf_we`=0 next cycle. `regf_waddr` and `regf_wdat` hold their last values.
- Push rule: every valid input not selected is pushed into the FIFO in the same cycle.
  - When both are pushed, `a` is pushed first and `m` second.
  - Up to 2 pushes per cycle.
- Pop: the FIFO head is popped when it is selected.
- Occupancy update: occupancy_next = occupancy + pushes_accepted − pop.
  - Free space for pushes is computed after the pop: DEPTH − occupancy + pop.
  - Pushes beyond free space are dropped. A dropped `a` push implies `m` is also dropped.
  - Any drop sets `overflow`=1. `overflow` clears only on reset.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is log2(DEPTH)+1 bits.
- Zero flush at selection: if the selected result has exponent bits [30:23]==0, `regf_wdat` is 32'h00000000 (sign also cleared). Otherwise the word passes unmodified.
- Ordering:
  - Results from the same unit are written in arrival order.
  - Among same-cycle arrivals, `a` precedes `m`.
  - Nothing arriving later overtakes a FIFO entry.
- No hazard checking on `*_dst`: two writes to the same address land in the order defined above.

## Timing
- Latency: a result selected in cycle N appears on `regf_we`/`regf_waddr`/`regf_wdat` in cycle N+1, for exactly one cycle.
- Throughput: one write per cycle, sustained.
- Conflict cost: each simultaneous `a`/`m` arrival adds one FIFO entry, which drains at one entry per cycle when no new input arrives.
- While the FIFO is non-empty, new arrivals are always pushed (head has priority). Occupancy stays constant under one arrival per cycle.
- `stall` and `busy` reflect state at the start of the cycle.
  - `stall` is advisory only. The block never back-pressures `a_valid`/`m_valid`.
  - The issue logic must stop early enough to cover unit pipeline depth (faddsub: 4 cycles).

## Test plan
- Single result: `a_valid`=1, `a_r`=32'h3F800000, `a_dst`=5 in cycle 0 → cycle 1: `regf_we`=1, waddr 5, wdat 32'h3F800000; cycle 2: `regf_we`=0; `busy` back to 0.
- Simultaneous arrival: `a` (dst 1, 32'h40000000) and `m` (dst 2, 32'h40400000) in cycle 0 → cycle 1 writes dst 1, cycle 2 writes dst 2. Occupancy is 1 during cycle 1, 0 after.
- Zero flush: `m_r`=32'h80400000 (exp 0), dst 9 → write of 32'h00000000 to 9. `m_r`=32'h80800000 passes unchanged.
- Fill/overflow with DEPTH=4: dual arrivals in cycles 0–4.
  - Occupancy goes 1,2,3,4; `stall` high from occupancy 2.
  - Dual arrival in cycle 4 with occupancy 4 accepts one push after the pop; `m` is dropped and `overflow`=1.
  - Remaining writes come out in the order a0,m0,a1,m1,a2,m2,a3,m3,a4.
- Wrap-around: 12 dual-arrival/idle pairs → all 24 writes correct and in order, with pointers wrapping 3 times.
- Async reset mid-drain: assert `alu_rst` between clock edges with occupancy 3 → `regf_we`, `busy`, `stall`, `overflow` are 0 immediately. After release, no stale writes occur.
